// File: rtl/dmem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_arbiter_if                                              |
// | Description : Bus bundle between the two data-memory requesters (port 0 = |
// |               CPU load/store unit, port 1 = loader/debug), the arbiter and |
// |               the single-ported data memory.                               |
// | Ports       : reqN/weN/addrN/wdataN/ctrlN  requester -> arbiter           |
// |               gntN/rvalidN/rdataN/errN     arbiter -> requester           |
// |               mem_addr/mem_wdata/mem_ctrl/mem_wr  arbiter -> memory       |
// |               mem_rdata                    memory -> arbiter (comb.)      |
// | Modports    : slave  = arbiter view, master = requesters + memory view    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface dmem_arbiter_if;
  // Port 0 (CPU load/store unit)
  logic        req0;
  logic        we0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic [2:0]  ctrl0;
  logic        gnt0;
  logic        rvalid0;
  logic [31:0] rdata0;
  logic        err0;

  // Port 1 (program loader / debug)
  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic [2:0]  ctrl1;
  logic        gnt1;
  logic        rvalid1;
  logic [31:0] rdata1;
  logic        err1;

  // Shared memory port
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ctrl;
  logic        mem_wr;
  logic [31:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0, ctrl0,
    input  req1, we1, addr1, wdata1, ctrl1,
    input  mem_rdata,
    output gnt0, rvalid0, rdata0, err0,
    output gnt1, rvalid1, rdata1, err1,
    output mem_addr, mem_wdata, mem_ctrl, mem_wr
  );

  modport master (
    output req0, we0, addr0, wdata0, ctrl0,
    output req1, we1, addr1, wdata1, ctrl1,
    output mem_rdata,
    input  gnt0, rvalid0, rdata0, err0,
    input  gnt1, rvalid1, rdata1, err1,
    input  mem_addr, mem_wdata, mem_ctrl, mem_wr
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_arbiter                                                 |
// | Description : Round-robin two-port arbiter and access sequencer in front  |
// |               of the byte-addressable RV32I data memory. Rejects illegal  |
// |               width codes, misaligned and out-of-range accesses before    |
// |               they reach memory; returns a registered one-cycle response. |
// | Ports       : clk  system clock (rising edge)                              |
// |               rst  asynchronous active-high reset                          |
// |               bus  dmem_arbiter_if.slave (requesters + memory port)       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 801
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [2:0] C_CTRL_IDLE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_q,  last_d;   // port granted most recently
  logic        port_q,  port_d;   // owner of the access in flight
  logic        we_q,    we_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ctrl_q,  ctrl_d;
  logic        bad_q,   bad_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        err0_q,  err0_d;
  logic        err1_q,  err1_d;

  // Arbitration and request qualification (only consumed in IDLE)
  logic        w_winner;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [2:0]  w_sel_ctrl;
  logic [2:0]  w_size;
  logic        w_illegal;
  logic        w_misalign;
  logic [32:0] w_last_byte;
  logic        w_out_of_range;
  logic        w_bad;

  // A lone requester wins; with both requesting, the port not granted last
  // wins. last_q resets to 1 so port 0 is favoured after reset.
  always_comb begin
    w_winner = 1'b0;
    if (bus.req0 && bus.req1) begin
      w_winner = ~last_q;
    end else if (bus.req1) begin
      w_winner = 1'b1;
    end
  end

  always_comb begin
    w_sel_we    = w_winner ? bus.we1    : bus.we0;
    w_sel_addr  = w_winner ? bus.addr1  : bus.addr0;
    w_sel_wdata = w_winner ? bus.wdata1 : bus.wdata0;
    w_sel_ctrl  = w_winner ? bus.ctrl1  : bus.ctrl0;
  end

  // Access size in bytes; 0 marks a width code with no defined access.
  always_comb begin
    case (w_sel_ctrl)
      3'b000, 3'b100: w_size = 3'd1;
      3'b001, 3'b101: w_size = 3'd2;
      3'b010:         w_size = 3'd4;
      default:        w_size = 3'd0;
    endcase
  end

  always_comb begin
    // Unsigned variants exist for loads only.
    w_illegal   = (w_size == 3'd0) || (w_sel_we && w_sel_ctrl[2]);
    w_misalign  = ((w_size == 3'd2) && w_sel_addr[0]) ||
                  ((w_size == 3'd4) && (w_sel_addr[1:0] != 2'b00));
    // 33-bit sum so an access starting near 0xFFFFFFFF cannot wrap back into
    // range. For illegal codes size 0 underflows, which is harmless.
    w_last_byte    = {1'b0, w_sel_addr} + {30'd0, w_size} - 33'd1;
    w_out_of_range = (w_last_byte >= 33'(MEM_BYTES));
    w_bad          = w_illegal || w_misalign || w_out_of_range;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      ctrl_q   <= C_CTRL_IDLE;
      bad_q    <= 1'b0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ctrl_q   <= ctrl_d;
      bad_q    <= bad_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ctrl_d   = ctrl_q;
    bad_d    = bad_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err0_d   = err0_q;
    err1_d   = err1_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = ST_ACCESS;
          last_d  = w_winner;
          port_d  = w_winner;
          we_d    = w_sel_we;
          addr_d  = w_sel_addr;
          wdata_d = w_sel_wdata;
          ctrl_d  = w_sel_ctrl;
          bad_d   = w_bad;
        end
      end

      ST_ACCESS: begin
        state_d = ST_RESP;
        // Stores leave rdata untouched; errors clear it.
        if (port_q) begin
          err1_d = bad_q;
          if (bad_q) begin
            rdata1_d = 32'd0;
          end else if (!we_q) begin
            rdata1_d = bus.mem_rdata;
          end
        end else begin
          err0_d = bad_q;
          if (bad_q) begin
            rdata0_d = 32'd0;
          end else if (!we_q) begin
            rdata0_d = bus.mem_rdata;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only, so they hold steady for the
  // whole ACCESS cycle and never depend combinationally on req*.
  always_comb begin
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    bus.mem_ctrl  = C_CTRL_IDLE;
    bus.mem_wr    = 1'b0;
    bus.gnt0      = 1'b0;
    bus.gnt1      = 1'b0;
    bus.rvalid0   = 1'b0;
    bus.rvalid1   = 1'b0;

    if (state_q == ST_ACCESS) begin
      bus.gnt0 = ~port_q;
      bus.gnt1 = port_q;
      if (!bad_q) begin
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_ctrl  = ctrl_q;
        bus.mem_wr    = we_q;
      end
    end else if (state_q == ST_RESP) begin
      bus.rvalid0 = ~port_q;
      bus.rvalid1 = port_q;
    end
  end

  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
  assign bus.err0   = err0_q;
  assign bus.err1   = err1_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dmem_arbiter                                              |
// | Description : Scoreboard bench for dmem_arbiter. Requests are predicted by |
// |               a byte-array reference model and queued; a monitor compares |
// |               every grant and response against the queue head.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int MEM_BYTES = 801;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int gnt_cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- Memory device attached to the memory port ----------------
  logic [7:0] dev_mem [MEM_BYTES];

  function automatic logic [7:0] dbyte(input logic [31:0] a);
    if (a < MEM_BYTES) return dev_mem[a];
    return 8'h00;
  endfunction

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = dbyte(bus.mem_addr);
    b1 = dbyte(bus.mem_addr + 32'd1);
    b2 = dbyte(bus.mem_addr + 32'd2);
    b3 = dbyte(bus.mem_addr + 32'd3);
    case (bus.mem_ctrl)
      3'b000:  bus.mem_rdata = {{24{b0[7]}}, b0};
      3'b001:  bus.mem_rdata = {{16{b1[7]}}, b1, b0};
      3'b010:  bus.mem_rdata = {b3, b2, b1, b0};
      3'b100:  bus.mem_rdata = {24'h0, b0};
      3'b101:  bus.mem_rdata = {16'h0, b1, b0};
      default: bus.mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if ((i == 0) || (i == 1 && bus.mem_ctrl[1:0] != 2'b00) || (i >= 2 && bus.mem_ctrl[1:0] == 2'b10)) begin
          if (bus.mem_addr + 32'(i) < MEM_BYTES) dev_mem[bus.mem_addr + 32'(i)] <= bus.mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------- Reference model ----------------
  typedef struct {
    bit          port;
    bit          we;
    bit          bad;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] ref_rd  [2];
  bit          ref_last = 1'b1;

  task automatic predict(input bit p, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] ctrl, output exp_t e);
    int size;
    bit bad;
    longint last;
    logic [31:0] v;
    case (ctrl)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    bad = (size == 0) || (we && ctrl >= 3'd4);
    if (!bad && (addr % size) != 0) bad = 1'b1;
    last = longint'({32'h0, addr}) + size - 1;
    if (!bad && last >= MEM_BYTES) bad = 1'b1;
    if (bad) begin
      ref_rd[p] = 32'h0;
    end else if (we) begin
      for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[addr + i]) << (8*i));
      if (ctrl == 3'd0) v = {{24{v[7]}}, v[7:0]};
      if (ctrl == 3'd1) v = {{16{v[15]}}, v[15:0]};
      ref_rd[p] = v;
    end
    e.port = p; e.we = we; e.bad = bad; e.ctrl = ctrl; e.addr = addr;
    e.rd0 = ref_rd[0]; e.rd1 = ref_rd[1];
    ref_last = p;
  endtask

  // ---------------- Monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (bus.gnt0 || bus.gnt1) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_gnt: gnt0=%0b gnt1=%0b with empty scoreboard", bus.gnt0, bus.gnt1);
        end else begin
          chk("gnt_port",    32'(bus.gnt1), 32'(sbq[0].port));
          chk("gnt_onehot",  32'(bus.gnt0 & bus.gnt1), 32'd0);
          chk("access_wr",   32'(bus.mem_wr), 32'(sbq[0].we && !sbq[0].bad));
          chk("access_ctrl", 32'(bus.mem_ctrl), sbq[0].bad ? 32'd7 : 32'(sbq[0].ctrl));
          if (!sbq[0].bad) chk("access_addr", bus.mem_addr, sbq[0].addr);
        end
        gnt_cyc = cyc;
      end else begin
        chk("idle_wr",   32'(bus.mem_wr), 32'd0);
        chk("idle_ctrl", 32'(bus.mem_ctrl), 32'd7);
      end
      if (bus.rvalid0 || bus.rvalid1) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rvalid: rvalid0=%0b rvalid1=%0b with empty scoreboard", bus.rvalid0, bus.rvalid1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rvalid_port",  32'(bus.rvalid1), 32'(e.port));
          chk("rvalid_delay", 32'(cyc - gnt_cyc), 32'd1);
          chk("resp_err",     32'(e.port ? bus.err1 : bus.err0), 32'(e.bad));
          chk("rdata0",       bus.rdata0, e.rd0);
          chk("rdata1",       bus.rdata1, e.rd1);
        end
      end
    end
  end

  // ---------------- Driver ----------------
  task automatic set_port(input bit p, input bit req, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] ctrl);
    if (p) begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; bus.ctrl1 = ctrl;
    end else begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; bus.ctrl0 = ctrl;
    end
  endtask

  task automatic do_access(input bit p, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] ctrl);
    exp_t e;
    int lat;
    bit got;
    predict(p, we, addr, wdata, ctrl, e);
    sbq.push_back(e);
    @(negedge clk);
    set_port(p, 1'b1, we, addr, wdata, ctrl);
    lat = 0; got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (p ? bus.gnt1 : bus.gnt0) got = 1'b1;
    end
    set_port(p, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    chk("gnt_latency", 32'(lat), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (bus.rvalid0 || bus.rvalid1) got = 1'b1;
    end
    chk("rvalid_seen", 32'(got), 32'd1);
  endtask

  // ---------------- Stimulus ----------------
  initial begin
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0; bus.ctrl0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0; bus.ctrl1 = 0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      dev_mem[i] = b;
      ref_mem[i] = b;
    end
    ref_rd[0] = 32'h0;
    ref_rd[1] = 32'h0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_gnt",    32'({bus.gnt0, bus.gnt1}), 32'd0);
    chk("rst_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 32'd0);
    chk("rst_err",    32'({bus.err0, bus.err1}), 32'd0);
    chk("rst_rdata0", bus.rdata0, 32'h0);
    chk("rst_rdata1", bus.rdata1, 32'h0);
    chk("rst_maddr",  bus.mem_addr, 32'h0);
    chk("rst_mwdata", bus.mem_wdata, 32'h0);
    chk("rst_mctrl",  32'(bus.mem_ctrl), 32'd7);
    chk("rst_mwr",    32'(bus.mem_wr), 32'd0);
    rst = 1'b0;

    // Reset asserted in the middle of an ACCESS cycle of a SW
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b1, 32'h100, 32'h12345678, 3'd2);
    @(negedge clk);
    chk("abort_gnt", 32'(bus.gnt0), 32'd1);
    chk("abort_wr_before", 32'(bus.mem_wr), 32'd1);
    set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    rst = 1'b1;
    #1;
    chk("abort_wr_drop", 32'(bus.mem_wr), 32'd0);
    chk("abort_ctrl",    32'(bus.mem_ctrl), 32'd7);
    chk("abort_gnt_drop", 32'(bus.gnt0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 32'd0);
    end
    ref_last = 1'b1;   // reset favours port 0 again
    mon_en = 1'b1;

    // Contention: both ports held high from reset -> 0,1,0,1,...
    begin
      int n_gnt;
      exp_t e;
      for (int k = 0; k < 8; k++) begin
        bit p;
        p = ~ref_last;
        if (p) predict(p, 1'b0, 32'h40, 32'h0, 3'd2, e);
        else   predict(p, 1'b1, 32'h40, 32'hC0DE0000 + 32'(k), 3'd2, e);
        sbq.push_back(e);
      end
      set_port(1'b0, 1'b1, 1'b1, 32'h40, 32'hC0DE0000, 3'd2);
      set_port(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 3'd2);
      n_gnt = 0;
      for (int i = 0; i < 40 && n_gnt < 8; i++) begin
        @(negedge clk);
        if (bus.gnt0 || bus.gnt1) begin
          n_gnt++;
          // Port 0 stores a fresh value each time it will be granted next.
          if (bus.gnt1) bus.wdata0 = 32'hC0DE0000 + 32'(n_gnt);
        end
      end
      set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
      set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
      chk("contention_grants", 32'(n_gnt), 32'd8);
      repeat (3) @(negedge clk);
    end

    // Store/load on port 0
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2);
    do_access(1'b0, 1'b0, 32'h13, 32'h0, 3'd0);
    chk("lb_sext", bus.rdata0, 32'hFFFFFFDE);
    do_access(1'b0, 1'b0, 32'h13, 32'h0, 3'd4);
    chk("lbu_zext", bus.rdata0, 32'h000000DE);
    do_access(1'b1, 1'b0, 32'h12, 32'h0, 3'd1);
    chk("lh_sext", bus.rdata1, 32'hFFFFDEAD);

    // Alignment, range, illegal codes
    do_access(1'b1, 1'b0, 32'h22, 32'h0, 3'd2);
    chk("misalign_err", 32'(bus.err1), 32'd1);
    chk("misalign_rdata", bus.rdata1, 32'h0);
    do_access(1'b0, 1'b1, 32'h31E, 32'hAABBCCDD, 3'd2);
    chk("range_sw_err", 32'(bus.err0), 32'd1);
    do_access(1'b0, 1'b1, 32'h320, 32'h000000A5, 3'd0);
    chk("range_sb_ok", 32'(bus.err0), 32'd0);
    do_access(1'b1, 1'b0, 32'h320, 32'h0, 3'd4);
    chk("range_sb_data", bus.rdata1, 32'h000000A5);
    do_access(1'b1, 1'b0, 32'h31C, 32'h0, 3'd2);
    do_access(1'b1, 1'b1, 32'h30, 32'h11223344, 3'd4);
    chk("store_lbu_err", 32'(bus.err1), 32'd1);
    do_access(1'b0, 1'b0, 32'h30, 32'h0, 3'd7);
    chk("ctrl7_err", 32'(bus.err0), 32'd1);
    do_access(1'b0, 1'b0, 32'h30, 32'h0, 3'd2);
    do_access(1'b1, 1'b0, 32'h11, 32'h0, 3'd5);
    do_access(1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 3'd0);
    do_access(1'b1, 1'b0, 32'hFFFFFFFE, 32'h0, 3'd1);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      bit p, we;
      logic [2:0] ctrl;
      logic [31:0] addr;
      int sel;
      p = 1'($urandom);
      we = 1'($urandom);
      sel = int'($urandom_range(0, 11));
      case (sel)
        0, 1:    ctrl = 3'd0;
        2, 3:    ctrl = 3'd1;
        4, 5, 6: ctrl = 3'd2;
        7:       ctrl = 3'd4;
        8:       ctrl = 3'd5;
        default: ctrl = 3'($urandom);
      endcase
      if (we && ctrl[2] && $urandom_range(0, 3) != 0) ctrl[2] = 1'b0;
      addr = 32'($urandom_range(0, 820));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(ctrl[1:0] == 2'b10 ? 3 : (ctrl[0] ? 1 : 0));
      if ($urandom_range(0, 15) == 0) addr = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
      do_access(p, we, addr, $urandom, ctrl);
    end

    begin
      int w;
      w = 0;
      while (sbq.size() != 0 && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
